// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter, one byte per grant.
//            Define UART_TX_ARB_LOCK_EN for packet locking via req_last_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NREQ-1:0]   req_last_i,
`endif
    output logic [NREQ-1:0]   req_ready_o,
    input  logic              uart_busy_i,
    output logic              uart_wr_o,
    output logic [7:0]        uart_dat_o,
    output logic [PTR_W-1:0]  grant_id_o,
    output logic              active_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_wr;
    logic [7:0]       r_hold;
    logic [PTR_W-1:0] r_grant;
    logic             r_active;

    logic [7:0]       w_bytes [NREQ];
    logic [NREQ-1:0]  w_cand;
    logic [PTR_W-1:0] w_winner;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    logic             w_grant;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_bytes[g] = req_data_i[8*g +: 8];
        end
    endgenerate

`ifdef UART_TX_ARB_LOCK_EN
    logic r_locked;
    // While a packet is open only its owner may compete.
    assign w_cand = r_locked ? (req_valid_i & (NREQ'(1) << r_grant)) : req_valid_i;
`else
    assign w_cand = req_valid_i;
`endif

    // Search starts just above the last grant so it ends up lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = PTR_W'((int'(r_grant) + i) % NREQ);
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant     = (r_state == ST_IDLE) && !uart_busy_i && w_found;
    assign req_ready_o = (w_grant && !sys_rst_i) ? (NREQ'(1) << w_winner) : '0;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state  <= ST_IDLE;
            r_wr     <= 1'b0;
            r_hold   <= 8'h00;
            r_grant  <= PTR_W'(NREQ - 1);
            r_active <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            r_locked <= 1'b0;
`endif
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_hold   <= w_bytes[w_winner];
                        r_grant  <= w_winner;
                        r_wr     <= 1'b1;
                        r_active <= 1'b1;
                        r_state  <= ST_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                        r_locked <= !req_last_i[w_winner];
`endif
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (uart_busy_i) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!uart_busy_i) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_wr_o  = r_wr;
    assign uart_dat_o = r_hold;
    assign grant_id_o = r_grant;
    assign active_o   = r_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter with a UART model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] valid = 4'h0;
    logic [31:0] data = 32'h0;
    logic [3:0] last  = 4'hF;
    logic [3:0] ready;
    logic       uart_busy;
    logic       uart_wr;
    logic [7:0] uart_dat;
    logic [1:0] grant_id;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int busy_len = 11;
    int wr_busy_viol = 0;
    int onehot_viol = 0;
    int ready_busy_viol = 0;
    byte unsigned wr_q[$];
    byte unsigned acc_q[$];
    int acc_id_q[$];

    uart_tx_arbiter #(.NREQ(4), .PTR_W(2)) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .req_valid_i (valid),
        .req_data_i  (data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_last_i  (last),
`endif
        .req_ready_o (ready),
        .uart_busy_i (uart_busy),
        .uart_wr_o   (uart_wr),
        .uart_dat_o  (uart_dat),
        .grant_id_o  (grant_id),
        .active_o    (active)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after a write, lasts busy_len cycles.
    assign uart_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (uart_wr) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (uart_wr) begin
                wr_q.push_back(uart_dat);
                if (uart_busy) wr_busy_viol <= wr_busy_viol + 1;
            end
            for (int k = 0; k < 4; k++) begin
                if (ready[k] && valid[k]) begin
                    acc_q.push_back(data[8*k +: 8]);
                    acc_id_q.push_back(k);
                end
            end
            if (ready != 4'h0 && !$onehot(ready)) onehot_viol <= onehot_viol + 1;
            if (ready != 4'h0 && uart_busy) ready_busy_viol <= ready_busy_viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!active && !uart_busy) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL %s_idle_timeout: active=%0b busy=%0b required idle", tag, active, uart_busy);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ready != 4'h0) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++; n_errors++;
            $display("FAIL %s_ready_timeout: ready=%b required a pulse", tag, ready);
        end
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 4'h0) begin n_errors++; $display("FAIL rst_ready: got %b required 0000", ready); end
        n_checks++; if (uart_wr !== 1'b0) begin n_errors++; $display("FAIL rst_wr: got %b required 0", uart_wr); end
        n_checks++; if (uart_dat !== 8'h00) begin n_errors++; $display("FAIL rst_dat: got %h required 00", uart_dat); end
        n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL rst_active: got %b required 0", active); end
        n_checks++; if (grant_id !== 2'd3) begin n_errors++; $display("FAIL rst_grant: got %0d required 3", grant_id); end
        tick(); rst = 1'b0;
    endtask

    task automatic test_single();
        wr_q.delete(); acc_q.delete();
        busy_len = 11;
        data = 32'hEE41EEEE;
        tick(); valid = 4'b0100;
        wait_ready("single");
        n_checks++; if (ready !== 4'b0100) begin n_errors++; $display("FAIL single_ready: got %b required 0100", ready); end
        tick(); valid = 4'b0000;
        @(negedge clk);
        n_checks++; if (uart_wr !== 1'b1) begin n_errors++; $display("FAIL single_wr: got %b required 1", uart_wr); end
        n_checks++; if (uart_dat !== 8'h41) begin n_errors++; $display("FAIL single_dat: got %h required 41", uart_dat); end
        n_checks++; if (grant_id !== 2'd2) begin n_errors++; $display("FAIL single_grant: got %0d required 2", grant_id); end
        wait_idle("single");
        n_checks++; if (wr_q.size() != 1) begin n_errors++; $display("FAIL single_wr_count: got %0d required 1", wr_q.size()); end
        n_checks++; if (uart_dat !== 8'h41) begin n_errors++; $display("FAIL single_dat_hold: got %h required 41", uart_dat); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        bit seen = 1'b0;
        bit in_frame = 1'b0;
        data = 32'h00000055;
        busy_len = 11;
        tick(); valid = 4'b0001;
        for (int i = 0; i < 40 && !in_frame; i++) begin
            @(negedge clk);
            if (active && uart_busy) in_frame = 1'b1;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ready !== 4'h0) begin n_errors++; $display("FAIL midrst_ready: got %b required 0000", ready); end
        n_checks++; if (uart_wr !== 1'b0) begin n_errors++; $display("FAIL midrst_wr: got %b required 0", uart_wr); end
        n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL midrst_active: got %b required 0", active); end
        n_checks++; if (uart_dat !== 8'h00) begin n_errors++; $display("FAIL midrst_dat: got %h required 00", uart_dat); end
        n_checks++; if (grant_id !== 2'd3) begin n_errors++; $display("FAIL midrst_grant: got %0d required 3", grant_id); end
        tick(); rst = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready != 4'h0) begin
                seen = 1'b1;
                if (uart_busy) bad++;
            end
        end
        n_checks++; if (!seen || ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_regrant: got %b required 0001", ready); end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL midrst_ready_while_busy: got %0d required 0", bad); end
        tick(); valid = 4'b0000;
        wait_idle("midrst");
    endtask

    task automatic test_round_robin();
        byte unsigned exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        wr_q.delete(); acc_q.delete(); acc_id_q.delete();
        busy_len = 4;
        data = 32'h13121110;
        valid = 4'b1111;
        for (int i = 0; i < 200 && wr_q.size() < 5; i++) @(negedge clk);
        tick(); valid = 4'b0000;
        wait_idle("rr");
        if (wr_q.size() < 5) begin
            n_checks++; n_errors++;
            $display("FAIL rr_count: got %0d writes required 5", wr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wr_q[i] !== exp[i]) begin n_errors++; $display("FAIL rr_byte%0d: got %h required %h", i, wr_q[i], exp[i]); end
            end
        end
        n_checks++; if (acc_q.size() != 5) begin n_errors++; $display("FAIL rr_accepts: got %0d required 5", acc_q.size()); end
        n_checks++; if (onehot_viol != 0) begin n_errors++; $display("FAIL rr_onehot: got %0d violations required 0", onehot_viol); end
    endtask

    task automatic test_wrap();
        data = 32'h33000030;
        tick(); valid = 4'b1000;
        wait_ready("wrap_setup");
        tick(); valid = 4'b0000;
        wait_idle("wrap_setup");
        n_checks++; if (grant_id !== 2'd3) begin n_errors++; $display("FAIL wrap_grant3: got %0d required 3", grant_id); end
        wr_q.delete(); acc_id_q.delete();
        tick(); valid = 4'b1001;
        for (int i = 0; i < 100 && wr_q.size() < 2; i++) @(negedge clk);
        tick(); valid = 4'b0000;
        wait_idle("wrap");
        if (wr_q.size() < 2 || acc_id_q.size() < 2) begin
            n_checks++; n_errors++;
            $display("FAIL wrap_count: got %0d writes required 2", wr_q.size());
        end else begin
            n_checks++; if (acc_id_q[0] != 0) begin n_errors++; $display("FAIL wrap_first_id: got %0d required 0", acc_id_q[0]); end
            n_checks++; if (acc_id_q[1] != 3) begin n_errors++; $display("FAIL wrap_second_id: got %0d required 3", acc_id_q[1]); end
            n_checks++; if (wr_q[0] !== 8'h30) begin n_errors++; $display("FAIL wrap_first_byte: got %h required 30", wr_q[0]); end
            n_checks++; if (wr_q[1] !== 8'h33) begin n_errors++; $display("FAIL wrap_second_byte: got %h required 33", wr_q[1]); end
        end
    endtask

    task automatic test_busy_protocol();
        int cycles = 0;
        int mism = 0;
        int first_bad = -1;
        wr_q.delete(); acc_q.delete(); acc_id_q.delete();
        while (wr_q.size() < 1000 && cycles < 40000) begin
            tick();
            valid    = 4'($urandom_range(0, 15));
            data     = $urandom;
            busy_len = $urandom_range(1, 6);
            cycles++;
        end
        valid = 4'b0000;
        wait_idle("busy");
        n_checks++; if (wr_q.size() < 1000) begin n_errors++; $display("FAIL busy_frames: got %0d required 1000", wr_q.size()); end
        n_checks++; if (acc_q.size() != wr_q.size()) begin n_errors++; $display("FAIL busy_acc_vs_wr: got %0d accepts required %0d", acc_q.size(), wr_q.size()); end
        for (int i = 0; i < wr_q.size() && i < acc_q.size(); i++) begin
            if (wr_q[i] !== acc_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_checks++; if (mism != 0) begin n_errors++; $display("FAIL busy_order: got %0d mismatches (first at %0d) required 0", mism, first_bad); end
        n_checks++; if (wr_busy_viol != 0) begin n_errors++; $display("FAIL busy_wr_while_busy: got %0d required 0", wr_busy_viol); end
        n_checks++; if (ready_busy_viol != 0) begin n_errors++; $display("FAIL busy_ready_while_busy: got %0d required 0", ready_busy_viol); end
        n_checks++; if (onehot_viol != 0) begin n_errors++; $display("FAIL busy_onehot: got %0d required 0", onehot_viol); end
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    task automatic test_lock();
        byte unsigned exp [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB2};
        int r1 = 0;
        int r2bad = 0;
        do_reset();
        wr_q.delete(); acc_q.delete(); acc_id_q.delete();
        busy_len = 3;
        data = 32'h00B2A100;
        last = 4'b1101;
        valid = 4'b0110;
        for (int i = 0; i < 300 && wr_q.size() < 4; i++) begin
            @(negedge clk);
            if (ready[2] && r1 < 3) r2bad++;
            if (ready[1]) begin
                r1++;
                tick();
                data[15:8] = 8'(8'hA1 + r1);
                last[1] = (r1 == 2);
                if (r1 == 3) valid[1] = 1'b0;
            end
        end
        tick(); valid = 4'b0000; last = 4'hF;
        wait_idle("lock");
        if (wr_q.size() < 4) begin
            n_checks++; n_errors++;
            $display("FAIL lock_count: got %0d writes required 4", wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_q[i] !== exp[i]) begin n_errors++; $display("FAIL lock_byte%0d: got %h required %h", i, wr_q[i], exp[i]); end
            end
        end
        n_checks++; if (r2bad != 0) begin n_errors++; $display("FAIL lock_r2_ready: got %0d pulses required 0", r2bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_wrap();
        test_busy_protocol();
`ifdef UART_TX_ARB_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
